cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Round-robin arbiter for the common data bus (CDB) shared by the add, mult and load functional units.
- Each cycle it selects at most one completing unit and drives that unit's ROB tag, result and branch outcome onto a registered CDB.
- The CDB feeds the reorder buffer's result-write port (`cdb_rob_dest`, `cdb_data`, `CTRL_incoming_data`, `CTRL_PC`).
- A ROB flush request discards in-flight broadcasts.

Parameters:
- NUM_REQ, 3, number of requesting functional units (0=add, 1=mult, 2=load).
- DATA_W, 64, result width.
- TAG_W, 2, ROB entry tag width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  unit i has a completed result.
- req_tag  input  NUM_REQ*TAG_W  ROB tag of unit i, slice [i*TAG_W +: TAG_W].
- req_data  input  NUM_REQ*DATA_W  result of unit i, slice [i*DATA_W +: DATA_W].
- req_taken  input  NUM_REQ  branch-taken flag of unit i (0 for non-branch).
- req_ready  output  NUM_REQ  combinational one-hot grant; unit i's result is accepted at the edge where req_valid[i] and req_ready[i] are both 1.
- flush  input  1  ROB flush (from CTRL_flushRegFile).
- cdb_valid  output  1  registered; drives CTRL_incoming_data.
- cdb_rob_dest  output  TAG_W  registered ROB tag.
- cdb_data  output  DATA_W  registered result.
- cdb_taken  output  1  registered branch outcome; drives CTRL_PC.

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous, active-low.
- Reset (rst_n=0 at an edge):
  - cdb_valid=0, cdb_rob_dest=0, cdb_data=0, cdb_taken=0.
  - rr_ptr=0.
  - req_ready forced to all-0 while rst_n=0.
- State: rr_ptr (clog2(NUM_REQ) bits) names the highest-priority requester this cycle.
- Grant (combinational):
  - Scan i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - The first i with req_valid[i]=1 wins; req_ready is one-hot on the winner.
  - req_ready is all-0 if there is no valid request, flush=1, or rst_n=0.
  - req_ready never depends on the winner's tag or data.
- On an edge with a winner w:
  - cdb_valid<=1.
  - cdb_rob_dest<=req_tag[w], cdb_data<=req_data[w], cdb_taken<=req_taken[w].
  - rr_ptr<=(w+1) mod NUM_REQ.
- On an edge with no winner and no flush: cdb_valid<=0, cdb_rob_dest<=0, cdb_data<=0, cdb_taken<=0; rr_ptr holds.
- Latency: result appears on the CDB exactly 1 cycle after the acceptance edge. Throughput is 1 broadcast per cycle, back-to-back.
- Requester rules:
  - A requester holds valid, tag, data and taken stable until accepted.
  - A requester may drop valid before acceptance (e.g. on its own flush). The arbiter keeps no per-requester state, so nothing is remembered.
- Flush (flush=1 at an edge):
  - No grant.
  - cdb_valid<=0 and all CDB fields <=0.
  - rr_ptr<=0.
  - Flush has priority over any pending request. Requests held across the flush are granted normally once flush=0.
- Fairness: under continuous requests from k units, each unit is granted once every k cycles. No starvation bound exceeds NUM_REQ-1 cycles of waiting.
- Wrap-around: rr_ptr increments modulo NUM_REQ, so winner NUM_REQ-1 sets rr_ptr to 0.
- Tags are passed through unchanged. There are no duplicate-tag checks; the ROB owns tag uniqueness.
- Simultaneous reset and flush: reset wins (same resulting state).

Test Plan:
- Reset: rst_n=0 for 2 cycles with all req_valid=1 -> req_ready=000 and cdb_valid=0 throughout; after release, unit 0 is granted first.
- Single unit: only mult valid (tag=2, data=0x1234, taken=0) -> req_ready=010 that cycle; next cycle cdb_valid=1, cdb_rob_dest=2, cdb_data=0x1234; following cycle cdb_valid=0.
- Three simultaneous, rr_ptr=0, held continuously -> grants 001, 010, 100, 001; CDB tags follow units 0,1,2,0 on consecutive cycles with no bubbles.
- Round-robin resume: grant to load (rr_ptr→0), then add and load valid -> add wins; then load alone -> load wins. Branch result with taken=1 on load -> cdb_taken=1 for that one cycle.
- Flush: add valid and flush=1 on the same edge -> no grant, next cdb_valid=0, rr_ptr=0; add held, flush=0 -> add granted next edge with its original tag and data.
- Reset mid-stream: during continuous requests from all units, rst_n=0 for one edge -> CDB cleared and rr_ptr=0; after release, unit 0 is granted first.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus shared by the
// add (0), mult (1) and load (2) functional units. The grant is
// combinational, and the bus is registered with one cycle of latency.
// A ROB flush clears the bus and returns priority to unit 0.
module cdb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_taken,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       flush,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_rob_dest,
  output logic [DATA_W-1:0]          cdb_data,
  output logic                       cdb_taken
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Highest-priority requester for the current cycle.
  logic [PTR_W-1:0]   rr_ptr;

  logic               win_found_s;
  logic [PTR_W-1:0]   win_idx_s;
  logic [PTR_W-1:0]   next_ptr_s;
  logic               grant_en_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [TAG_W-1:0]   sel_tag_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic               sel_taken_s;

  // Scan the requesters starting at rr_ptr and wrapping; the first valid one wins.
  always_comb begin
    int idx;
    win_found_s = 1'b0;
    win_idx_s   = {PTR_W{1'b0}};
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!win_found_s && req_valid[idx]) begin
        win_found_s = 1'b1;
        win_idx_s   = PTR_W'(idx);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // A grant is only issued out of reset and outside a flush; the winner
  // choice itself depends only on the valid bits, never on tag or data.
  always_comb begin
    grant_en_s = rst_n && !flush && win_found_s;
    grant_s    = {NUM_REQ{1'b0}};
    if (grant_en_s) begin
      grant_s[win_idx_s] = 1'b1;
    end else begin
      grant_s = {NUM_REQ{1'b0}};
    end
  end

  assign req_ready = grant_s;

  // Priority rotates to the unit just after the winner, wrapping to unit 0.
  always_comb begin
    if (win_idx_s == PTR_W'(NUM_REQ - 1)) begin
      next_ptr_s = {PTR_W{1'b0}};
    end else begin
      next_ptr_s = win_idx_s + PTR_W'(1);
    end
  end

  // Select the winner's tag, result and branch outcome for the bus.
  always_comb begin
    sel_tag_s   = req_tag[win_idx_s*TAG_W +: TAG_W];
    sel_data_s  = req_data[win_idx_s*DATA_W +: DATA_W];
    sel_taken_s = req_taken[win_idx_s];
  end

  // Bus register and priority pointer; reset and flush both clear the bus
  // and return priority to unit 0, and an idle cycle zeroes the bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cdb_valid    <= 1'b0;
      cdb_rob_dest <= {TAG_W{1'b0}};
      cdb_data     <= {DATA_W{1'b0}};
      cdb_taken    <= 1'b0;
      rr_ptr       <= {PTR_W{1'b0}};
    end else if (flush) begin
      cdb_valid    <= 1'b0;
      cdb_rob_dest <= {TAG_W{1'b0}};
      cdb_data     <= {DATA_W{1'b0}};
      cdb_taken    <= 1'b0;
      rr_ptr       <= {PTR_W{1'b0}};
    end else if (win_found_s) begin
      cdb_valid    <= 1'b1;
      cdb_rob_dest <= sel_tag_s;
      cdb_data     <= sel_data_s;
      cdb_taken    <= sel_taken_s;
      rr_ptr       <= next_ptr_s;
    end else begin
      cdb_valid    <= 1'b0;
      cdb_rob_dest <= {TAG_W{1'b0}};
      cdb_data     <= {DATA_W{1'b0}};
      cdb_taken    <= 1'b0;
      rr_ptr       <= rr_ptr;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus a randomized run, all
// checked against a small priority-distance reference model.
module tb_cdb_arbiter;

  localparam int N  = 3;
  localparam int DW = 64;
  localparam int TW = 2;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic [N-1:0]     req_valid;
  logic [N*TW-1:0]  req_tag;
  logic [N*DW-1:0]  req_data;
  logic [N-1:0]     req_taken;
  logic [N-1:0]     req_ready;
  logic             cdb_valid;
  logic [TW-1:0]    cdb_rob_dest;
  logic [DW-1:0]    cdb_data;
  logic             cdb_taken;

  logic [TW-1:0] t [N];
  logic [DW-1:0] d [N];
  logic          v [N];
  logic          k [N];

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_ptr;
  int            last_win;
  logic          e_valid;
  logic [TW-1:0] e_tag;
  logic [DW-1:0] e_data;
  logic          e_taken;

  assign req_valid = {v[2], v[1], v[0]};
  assign req_tag   = {t[2], t[1], t[0]};
  assign req_data  = {d[2], d[1], d[0]};
  assign req_taken = {k[2], k[1], k[0]};

  cdb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_tag(req_tag),
    .req_data(req_data), .req_taken(req_taken), .req_ready(req_ready),
    .flush(flush), .cdb_valid(cdb_valid), .cdb_rob_dest(cdb_rob_dest),
    .cdb_data(cdb_data), .cdb_taken(cdb_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner = valid unit with the smallest priority distance from m_ptr.
  function automatic int model_winner();
    int best, bestd;
    best = -1; bestd = N;
    if (!rst_n || flush) return -1;
    for (int i = 0; i < N; i++) begin
      if (v[i] && ((i - m_ptr + N) % N) < bestd) begin
        bestd = (i - m_ptr + N) % N;
        best  = i;
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    logic [N-1:0] r;
    w = model_winner();
    r = 3'b000;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  // Advance the model by one edge, then let the DUT take the same edge.
  task automatic tick();
    int w;
    w = model_winner();
    last_win = w;
    if (!rst_n || flush) begin
      e_valid = 1'b0; e_tag = '0; e_data = '0; e_taken = 1'b0; m_ptr = 0;
    end else if (w >= 0) begin
      e_valid = 1'b1; e_tag = t[w]; e_data = d[w]; e_taken = k[w];
      m_ptr = (w + 1) % N;
    end else begin
      e_valid = 1'b0; e_tag = '0; e_data = '0; e_taken = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; t[i] = '0; d[i] = '0; k[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    flush = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin v[i] = 1'b1; t[i] = TW'(i); d[i] = DW'(i + 100); end
    e_valid = 1'b0; e_tag = '0; e_data = '0; e_taken = 1'b0; m_ptr = 0;
    tick();
    for (int c = 0; c < 2; c++) begin
      total++;
      if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
      total++;
      if (cdb_valid !== 1'b0 || cdb_data !== 64'd0) begin
        bad++; $display("FAIL reset_cdb got valid=%b data=%h exp 0/0", cdb_valid, cdb_data);
      end
      tick();
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 3'b001) begin bad++; $display("FAIL reset_release_ready got=%b exp=001", req_ready); end
    tick();
    total++;
    if (cdb_valid !== 1'b1 || cdb_rob_dest !== 2'd0 || cdb_data !== 64'd100) begin
      bad++; $display("FAIL reset_first_grant got v=%b tag=%0d data=%h exp 1/0/64", cdb_valid, cdb_rob_dest, cdb_data);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_single();
    clear_inputs();
    v[1] = 1'b1; t[1] = 2'd2; d[1] = 64'h1234; k[1] = 1'b0;
    #1;
    total++;
    if (req_ready !== 3'b010) begin bad++; $display("FAIL single_ready got=%b exp=010", req_ready); end
    tick();
    v[1] = 1'b0;
    total++;
    if (cdb_valid !== 1'b1 || cdb_rob_dest !== 2'd2 || cdb_data !== 64'h1234 || cdb_taken !== 1'b0) begin
      bad++; $display("FAIL single_cdb got v=%b tag=%0d data=%h tk=%b exp 1/2/1234/0", cdb_valid, cdb_rob_dest, cdb_data, cdb_taken);
    end
    tick();
    total++;
    if (cdb_valid !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", cdb_valid); end
  endtask

  task automatic test_three();
    logic [N-1:0] gseq [4];
    logic [TW-1:0] tseq [4];
    gseq[0] = 3'b001; gseq[1] = 3'b010; gseq[2] = 3'b100; gseq[3] = 3'b001;
    tseq[0] = 2'd1;   tseq[1] = 2'd2;   tseq[2] = 2'd3;   tseq[3] = 2'd1;
    clear_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin v[i] = 1'b1; t[i] = TW'(i + 1); d[i] = DW'(64'hA0 + i); end
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (req_ready !== gseq[c]) begin bad++; $display("FAIL three_ready[%0d] got=%b exp=%b", c, req_ready, gseq[c]); end
      tick();
      total++;
      if (cdb_valid !== 1'b1 || cdb_rob_dest !== tseq[c]) begin
        bad++; $display("FAIL three_cdb[%0d] got v=%b tag=%0d exp 1/%0d", c, cdb_valid, cdb_rob_dest, tseq[c]);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_rr_resume();
    clear_inputs();
    v[2] = 1'b1; t[2] = 2'd3; d[2] = 64'h55;
    #1;
    total++;
    if (req_ready !== 3'b100) begin bad++; $display("FAIL rr_load_ready got=%b exp=100", req_ready); end
    tick();
    v[0] = 1'b1; t[0] = 2'd0; d[0] = 64'h66;
    #1;
    total++;
    if (req_ready !== 3'b001) begin bad++; $display("FAIL rr_add_wins got=%b exp=001", req_ready); end
    tick();
    v[0] = 1'b0; k[2] = 1'b1; t[2] = 2'd1; d[2] = 64'h77;
    #1;
    total++;
    if (req_ready !== 3'b100) begin bad++; $display("FAIL rr_load_alone got=%b exp=100", req_ready); end
    tick();
    clear_inputs();
    total++;
    if (cdb_taken !== 1'b1 || cdb_rob_dest !== 2'd1 || cdb_data !== 64'h77) begin
      bad++; $display("FAIL rr_taken got tk=%b tag=%0d data=%h exp 1/1/77", cdb_taken, cdb_rob_dest, cdb_data);
    end
    tick();
    total++;
    if (cdb_taken !== 1'b0 || cdb_valid !== 1'b0) begin
      bad++; $display("FAIL rr_taken_drop got tk=%b v=%b exp 0/0", cdb_taken, cdb_valid);
    end
  endtask

  task automatic test_flush();
    clear_inputs();
    v[0] = 1'b1; t[0] = 2'd0; d[0] = 64'h1;
    tick();                       // add wins, pointer moves to mult
    v[0] = 1'b1; t[0] = 2'd3; d[0] = 64'hABCD;
    v[1] = 1'b1; t[1] = 2'd2; d[1] = 64'h9999;
    flush = 1'b1;
    #1;
    total++;
    if (req_ready !== 3'b000) begin bad++; $display("FAIL flush_ready got=%b exp=000", req_ready); end
    tick();
    flush = 1'b0;
    total++;
    if (cdb_valid !== 1'b0 || cdb_data !== 64'd0) begin
      bad++; $display("FAIL flush_cdb got v=%b data=%h exp 0/0", cdb_valid, cdb_data);
    end
    #1;
    total++;
    if (req_ready !== 3'b001) begin bad++; $display("FAIL flush_ptr_reset got=%b exp=001", req_ready); end
    tick();
    total++;
    if (cdb_valid !== 1'b1 || cdb_rob_dest !== 2'd3 || cdb_data !== 64'hABCD) begin
      bad++; $display("FAIL flush_resume got v=%b tag=%0d data=%h exp 1/3/abcd", cdb_valid, cdb_rob_dest, cdb_data);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    for (int i = 0; i < N; i++) begin v[i] = 1'b1; t[i] = TW'(i); d[i] = DW'(64'hF0 + i); end
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== 3'b000) begin bad++; $display("FAIL midrst_ready got=%b exp=000", req_ready); end
    tick();
    rst_n = 1'b1;
    total++;
    if (cdb_valid !== 1'b0 || cdb_rob_dest !== 2'd0 || cdb_data !== 64'd0) begin
      bad++; $display("FAIL midrst_cdb got v=%b tag=%0d data=%h exp 0/0/0", cdb_valid, cdb_rob_dest, cdb_data);
    end
    #1;
    total++;
    if (req_ready !== 3'b001) begin bad++; $display("FAIL midrst_first got=%b exp=001", req_ready); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] er;
    clear_inputs();
    last_win = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        // A requester keeps its payload until accepted, but may drop valid.
        if (!v[i] || last_win == i) begin
          v[i] = ($urandom_range(0, 99) < 60);
          t[i] = TW'($urandom);
          d[i] = {$urandom, $urandom};
          k[i] = ($urandom_range(0, 3) == 0);
        end else if ($urandom_range(0, 19) == 0) begin
          v[i] = 1'b0;
        end
      end
      flush = ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      #1;
      er = exp_ready();
      total++;
      if (req_ready !== er) begin bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, er); end
      tick();
      total++;
      if (cdb_valid !== e_valid || cdb_rob_dest !== e_tag || cdb_data !== e_data || cdb_taken !== e_taken) begin
        bad++;
        $display("FAIL rand_cdb c=%0d got v=%b tag=%0d data=%h tk=%b exp v=%b tag=%0d data=%h tk=%b",
                 c, cdb_valid, cdb_rob_dest, cdb_data, cdb_taken, e_valid, e_tag, e_data, e_taken);
      end
    end
    rst_n = 1'b1;
    flush = 1'b0;
    clear_inputs();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_three();
    test_rr_resume();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
